// File: rtl/rah_echo_app.sv
// RAH loopback application: pops command bursts from the decoder queue and echoes them,
// optionally followed by an XOR checksum, or discards them with an error word on a bad opcode.
module rah_echo_app #(
    parameter int RAH_PACKET_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RAH_PACKET_WIDTH-1:0] in_data,
    input  logic                        q_empty,
    output logic                        request_data,
    input  logic                        wr_full,
    output logic                        w_en,
    output logic [RAH_PACKET_WIDTH-1:0] out_data,
    output logic [15:0]                 pkt_count,
    output logic [7:0]                  err_count
);

    localparam logic [7:0] OP_ECHO      = 8'h01;
    localparam logic [7:0] OP_ECHO_CSUM = 8'h02;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        DISCARD = 3'd3,
        CSUM    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic                        rd_valid;
    logic [15:0]                 req_left;
    logic [15:0]                 rcv_left;
    logic                        csum_mode;
    logic [RAH_PACKET_WIDTH-1:0] csum;

    logic [7:0]  hdr_op;
    logic [15:0] hdr_n;
    logic        hdr_known;
    logic        can_pop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign hdr_op    = in_data[47:40];
    assign hdr_n     = in_data[15:0];
    assign hdr_known = (hdr_op == OP_ECHO) || (hdr_op == OP_ECHO_CSUM);
    assign can_pop   = !rst && !q_empty && !wr_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (request_data) state_nxt = HDR;
            end
            HDR: begin
                if (rd_valid) begin
                    if (hdr_n != 16'd0)
                        state_nxt = hdr_known ? PAYLOAD : DISCARD;
                    else if (hdr_op == OP_ECHO_CSUM)
                        state_nxt = CSUM;
                    else
                        state_nxt = DONE;
                end
            end
            PAYLOAD: begin
                if (rd_valid && rcv_left == 16'd1)
                    state_nxt = csum_mode ? CSUM : DONE;
            end
            DISCARD: begin
                if (rd_valid && rcv_left == 16'd1) state_nxt = DONE;
            end
            CSUM: begin
                if (!wr_full) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first payload pop overlaps the header decode so a burst streams without a bubble.
    always_comb begin
        request_data = 1'b0;
        case (state)
            IDLE:             request_data = can_pop;
            HDR:              request_data = can_pop && rd_valid && (hdr_n != 16'd0);
            PAYLOAD, DISCARD: request_data = can_pop && (req_left != 16'd0);
            default:          request_data = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            w_en      <= 1'b0;
            out_data  <= '0;
            pkt_count <= 16'd0;
            err_count <= 8'd0;
            req_left  <= 16'd0;
            rcv_left  <= 16'd0;
            csum_mode <= 1'b0;
            csum      <= '0;
        end else begin
            rd_valid <= request_data;
            w_en     <= 1'b0;
            case (state)
                HDR: begin
                    if (rd_valid) begin
                        rcv_left  <= hdr_n;
                        req_left  <= hdr_n - {15'd0, request_data};
                        csum_mode <= (hdr_op == OP_ECHO_CSUM);
                        csum      <= '0;
                        w_en      <= 1'b1;
                        if (hdr_known) begin
                            out_data <= in_data;
                        end else begin
                            out_data  <= {8'hEE, 8'h00, hdr_op, 8'h00, hdr_n};
                            err_count <= sat_inc8(err_count);
                        end
                    end
                end
                PAYLOAD: begin
                    if (request_data) req_left <= req_left - 16'd1;
                    if (rd_valid) begin
                        out_data <= in_data;
                        w_en     <= 1'b1;
                        csum     <= csum ^ in_data;
                        rcv_left <= rcv_left - 16'd1;
                    end
                end
                DISCARD: begin
                    if (request_data) req_left <= req_left - 16'd1;
                    if (rd_valid)     rcv_left <= rcv_left - 16'd1;
                end
                CSUM: begin
                    if (!wr_full) begin
                        out_data <= csum;
                        w_en     <= 1'b1;
                    end
                end
                DONE: begin
                    pkt_count <= pkt_count + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rah_echo_app.sv
// Scoreboard bench for rah_echo_app: a queue-backed decoder FIFO feeds commands, a command-level
// model predicts the encoder word stream, and a monitor compares every written word.
module tb_rah_echo_app;

    logic        clk;
    logic        rst;
    logic [47:0] in_data;
    logic        q_empty;
    logic        request_data;
    logic        wr_full;
    logic        w_en;
    logic [47:0] out_data;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;

    rah_echo_app #(.RAH_PACKET_WIDTH(48)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .q_empty(q_empty),
        .request_data(request_data), .wr_full(wr_full), .w_en(w_en),
        .out_data(out_data), .pkt_count(pkt_count), .err_count(err_count)
    );

    logic [47:0] in_q[$];
    logic [47:0] exp_q[$];
    logic [47:0] pl_q[$];
    int          wr_cyc[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          m_pkt = 0;
    int          m_err = 0;
    logic        gaps = 1'b0;
    logic        rnd_full = 1'b0;
    logic        full_req = 1'b0;
    logic        fifo_pop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] rand48();
        logic [47:0] w;
        w[31:0]  = $urandom();
        w[47:32] = 16'($urandom());
        return w;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Decoder FIFO model: read data appears one cycle after a pop.
    always @(posedge clk) begin
        fifo_pop = request_data;
        #1;
        if (fifo_pop) begin
            if (in_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_underflow: got pop expected none (cycle %0d)", cyc);
                in_data = rand48();
            end else begin
                in_data = in_q.pop_front();
            end
        end else begin
            in_data = rand48();
        end
        q_empty = (in_q.size() == 0) || (gaps && $urandom_range(0, 3) == 0);
        wr_full = full_req || (rnd_full && $urandom_range(0, 3) == 0);
    end

    // Monitor: every write is matched against the scoreboard; pops must be legal.
    always @(negedge clk) begin
        if (w_en) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got %h expected no write (cycle %0d)", out_data, cyc);
            end else begin
                chk("out_word", out_data, exp_q.pop_front());
            end
        end
        if (request_data)
            chk("pop_legal", {46'd0, q_empty, wr_full}, 48'd0);
    end

    task automatic rnd_payload(input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(rand48());
    endtask

    // Command-level reference: what the encoder must see for one command.
    task automatic send_cmd(input logic [7:0] op, input logic [15:0] n);
        logic [47:0] hdr;
        logic [47:0] x;
        hdr = {op, 24'($urandom()), n};
        x   = '0;
        in_q.push_back(hdr);
        foreach (pl_q[i]) begin
            in_q.push_back(pl_q[i]);
            x = x ^ pl_q[i];
        end
        if (op == 8'h01 || op == 8'h02) begin
            exp_q.push_back(hdr);
            foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
            if (op == 8'h02) exp_q.push_back(x);
        end else begin
            exp_q.push_back({8'hEE, 8'h00, op, 8'h00, n});
            if (m_err < 255) m_err++;
        end
        m_pkt++;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
        end
        repeat (4) @(negedge clk);
        chk({name, "_pkt_count"}, 48'(pkt_count), 48'(m_pkt[15:0]));
        chk({name, "_err_count"}, 48'(err_count), 48'(m_err[7:0]));
    endtask

    initial begin
        logic [7:0] op;
        int k;
        rst = 1'b1;
        q_empty = 1'b1;
        wr_full = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_w_en", 48'(w_en), 48'd0);
        chk("reset_out_data", out_data, 48'd0);
        chk("reset_pkt_count", 48'(pkt_count), 48'd0);
        chk("reset_err_count", 48'(err_count), 48'd0);
        chk("reset_request", 48'(request_data), 48'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ECHO N=3 streamed back to back
        wr_cyc.delete();
        rnd_payload(3);
        send_cmd(8'h01, 16'd3);
        drain("t1");
        chk("t1_writes", 48'(wr_cyc.size()), 48'd4);
        if (wr_cyc.size() == 4)
            chk("t1_consecutive", 48'(wr_cyc[3] - wr_cyc[0]), 48'd3);

        // ECHO_CSUM N=2 with fixed payload
        pl_q.delete();
        pl_q.push_back(48'h0000FFFF0000);
        pl_q.push_back(48'h00FF00FF00FF);
        send_cmd(8'h02, 16'd2);
        drain("t2");

        // bad opcode discards its payload
        rnd_payload(2);
        send_cmd(8'h7F, 16'd2);
        drain("t3");

        // wr_full asserted for 3 cycles mid-burst
        rnd_payload(8);
        send_cmd(8'h01, 16'd8);
        k = 0;
        while (exp_q.size() > 6 && k < 200) begin
            @(negedge clk);
            k++;
        end
        full_req = 1'b1;
        repeat (3) @(negedge clk);
        full_req = 1'b0;
        drain("t4");

        // ECHO_CSUM with empty payload
        pl_q.delete();
        send_cmd(8'h02, 16'd0);
        drain("t5");

        // random back-to-back commands with queue gaps and encoder back-pressure
        gaps = 1'b1;
        rnd_full = 1'b1;
        for (int c = 0; c < 40; c++) begin
            k = $urandom_range(0, 9);
            if (k < 4) op = 8'h01;
            else if (k < 8) op = 8'h02;
            else begin
                op = 8'($urandom());
                while (op == 8'h01 || op == 8'h02) op = 8'($urandom());
            end
            k = $urandom_range(0, 6);
            rnd_payload(k);
            send_cmd(op, 16'(k));
        end
        drain("rand");
        gaps = 1'b0;
        rnd_full = 1'b0;
        repeat (2) @(negedge clk);

        // reset in the middle of a payload burst
        begin
            logic [47:0] hdr;
            hdr = 48'h010000000005;
            rnd_payload(5);
            in_q.push_back(hdr);
            foreach (pl_q[i]) in_q.push_back(pl_q[i]);
            exp_q.push_back(hdr);
            exp_q.push_back(pl_q[0]);
            exp_q.push_back(pl_q[1]);
        end
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 200) begin
            miscompares++;
            $display("FAIL t6_timeout: got %0d words pending expected 0", exp_q.size());
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        in_q.delete();
        exp_q.delete();
        m_pkt = 0;
        m_err = 0;
        chk("t6_reset_w_en", 48'(w_en), 48'd0);
        chk("t6_reset_out_data", out_data, 48'd0);
        chk("t6_reset_pkt_count", 48'(pkt_count), 48'd0);
        chk("t6_reset_err_count", 48'(err_count), 48'd0);
        chk("t6_reset_request", 48'(request_data), 48'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rnd_payload(1);
        send_cmd(8'h01, 16'd1);
        drain("t6");

        chk("final_scoreboard_empty", 48'(exp_q.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
